// File: rtl/kw_arb_pkt_mux_pkg.sv
// Shared types and sizing helpers for the packet mux stage behind the
// static-priority arbiter.
package kw_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_mux_state_t;

    // Index width for N requesters; never narrower than one bit.
    function automatic int kw_clog2_n(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/kw_arb_pkt_mux_if.sv
// Requester, arbiter and output-stream signals of the packet mux.
// The mux uses the slave view; its environment uses the master view.
interface kw_arb_pkt_mux_if #(
    parameter int N = 16,
    parameter int W = 32
);
    import kw_arb_pkg::*;

    localparam int IDXW = kw_clog2_n(N);

    logic [N-1:0]         in_valid;
    logic [N-1:0][W-1:0]  in_data;
    logic [N-1:0]         in_last;
    logic [N-1:0]         in_ready;
    logic [N-1:0]         arb_request;
    logic [N-1:0]         arb_lock;
    logic [N-1:0]         arb_grant;
    logic                 arb_granted;
    logic                 out_valid;
    logic [W-1:0]         out_data;
    logic                 out_last;
    logic [IDXW-1:0]      out_src;
    logic                 out_ready;

    modport slave (
        input  in_valid, in_data, in_last, arb_grant, arb_granted, out_ready,
        output in_ready, arb_request, arb_lock, out_valid, out_data, out_last, out_src
    );

    modport master (
        output in_valid, in_data, in_last, arb_grant, arb_granted, out_ready,
        input  in_ready, arb_request, arb_lock, out_valid, out_data, out_last, out_src
    );

endinterface

// File: rtl/kw_arb_pkt_mux_onehot_to_idx.sv
// One-hot to binary index encoder; an all-zero input yields index 0.
module kw_onehot_to_idx
    import kw_arb_pkg::*;
#(
    parameter int N = 16,
    localparam int IDXW = kw_clog2_n(N)
) (
    input  logic [N-1:0]    onehot_i,
    output logic [IDXW-1:0] idx_o
);

    always_comb begin
        idx_o = '0;
        for (int i = 0; i < N; i++) begin
            if (onehot_i[i]) begin
                idx_o = idx_o | i[IDXW-1:0];
            end
        end
    end

endmodule

// File: rtl/kw_arb_pkt_mux.sv
// Packet mux behind the static-priority arbiter: latches the winner, locks
// the arbiter for the whole packet and forwards its beats through one
// registered valid/ready stage.
//
//   state   | meaning
//   --------+----------------------------------------------
//   ST_IDLE | no owner; waiting for a one-hot grant
//   ST_BUSY | owner latched, arbiter locked, packet in flight
module kw_arb_pkt_mux
    import kw_arb_pkg::*;
#(
    parameter int N = 16,
    parameter int W = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    kw_arb_pkt_mux_if.slave   bus
);

    localparam int IDXW = kw_clog2_n(N);

    arb_mux_state_t   state_q;
    logic [N-1:0]     owner_q;

    logic             out_valid_q, out_valid_d;
    logic [W-1:0]     out_data_q,  out_data_d;
    logic             out_last_q,  out_last_d;
    logic [IDXW-1:0]  out_src_q,   out_src_d;

    logic [IDXW-1:0]  sel_idx;
    logic [N-1:0]     in_ready_c;
    logic             can_load;
    logic             xfer;
    logic             sel_last;
    logic             grant_ok;

    kw_onehot_to_idx #(.N(N)) u_sel (
        .onehot_i (owner_q),
        .idx_o    (sel_idx)
    );

    assign can_load   = ~out_valid_q | bus.out_ready;
    assign in_ready_c = (state_q == ST_BUSY) ? (owner_q & {N{can_load}}) : '0;
    assign xfer       = |(bus.in_valid & in_ready_c);
    assign sel_last   = bus.in_last[sel_idx];

    // Zero or multi-bit grants never start a packet.
    assign grant_ok = bus.arb_granted
                    && (bus.arb_grant != '0)
                    && ((bus.arb_grant & (bus.arb_grant - N'(1))) == '0);

    assign bus.arb_request = bus.in_valid;
    assign bus.arb_lock    = (state_q == ST_BUSY) ? owner_q : '0;
    assign bus.in_ready    = in_ready_c;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_data    = out_data_q;
    assign bus.out_last    = out_last_q;
    assign bus.out_src     = out_src_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_ok) begin
                        owner_q <= bus.arb_grant;
                        state_q <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (xfer && sel_last) begin
                        owner_q <= '0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    owner_q <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Single-entry output stage: load on transfer, drain when accepted.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_src_d   = out_src_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = bus.in_data[sel_idx];
            out_last_d  = sel_last;
            out_src_d   = sel_idx;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_src_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_src_q   <= out_src_d;
        end
    end

endmodule

// File: tb/tb_kw_arb_pkt_mux.sv
// Directed bench for kw_arb_pkt_mux: stimulus pushes expected beats into a
// queue, a negedge monitor pops and compares every accepted output beat.
module tb_kw_arb_pkt_mux;

    localparam int N = 16;
    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] data;
        logic         is_last;
        logic [3:0]   src;
    } beat_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   pushed;
    int   seen;
    int   cyc_used;
    beat_t exp_q[$];

    kw_arb_pkt_mux_if #(.N(N), .W(W)) bus ();

    kw_arb_pkt_mux #(.N(N), .W(W)) dut (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: a beat is consumed on the edge after valid & ready.
    always @(negedge clk) begin
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            beat_t e;
            seen++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat: got data=%0h last=%0b src=%0d expected none",
                         bus.out_data, bus.out_last, bus.out_src);
            end else begin
                e = exp_q.pop_front();
                if (bus.out_data !== e.data || bus.out_last !== e.is_last || bus.out_src !== e.src) begin
                    errors++;
                    $display("FAIL beat: got data=%0h last=%0b src=%0d expected data=%0h last=%0b src=%0d",
                             bus.out_data, bus.out_last, bus.out_src, e.data, e.is_last, e.src);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (bus.arb_granted === 1'b1) begin
            assert ($onehot0(bus.arb_grant))
            else $error("FAIL arb_grant_onehot: got %0h expected at most one bit", bus.arb_grant);
        end
    end

    task automatic push_beat(input logic [W-1:0] d, input logic l, input int s);
        beat_t e;
        e.data    = d;
        e.is_last = l;
        e.src     = s[3:0];
        exp_q.push_back(e);
        pushed++;
    endtask

    // Grant src, then move an n-beat packet; optional 1,0,0,1 out_ready
    // pattern and a 3-cycle owner valid drop before beat stall_at.
    task automatic send_pkt(input int src, input int n, input logic [W-1:0] base,
                            input logic [N-1:0] mid_grant, input bit use_bp,
                            input int stall_at, output int cycles);
        logic [N-1:0] own;
        logic [3:0]   bp_pat;
        logic [W-1:0] held;
        bit           hold_chk;
        bit           xf;
        int           b;
        int           cyc;
        int           stall_cnt;
        own       = N'(1) << src;
        bp_pat    = 4'b1001;
        b         = 0;
        cyc       = 0;
        stall_cnt = 0;
        bus.in_valid[src] = 1'b1;
        bus.in_data[src]  = base;
        bus.in_last[src]  = (n == 1);
        bus.arb_grant     = own;
        bus.arb_granted   = 1'b1;
        tick();
        bus.arb_grant   = mid_grant;
        bus.arb_granted = |mid_grant;
        while (b < n && cyc < 40) begin
            bus.out_ready = (use_bp && cyc < 4) ? bp_pat[cyc] : 1'b1;
            if (b == stall_at && stall_cnt < 3) begin
                bus.in_valid[src] = 1'b0;
                stall_cnt++;
            end else begin
                bus.in_valid[src] = 1'b1;
            end
            #1;
            chk("lock_owner", bus.arb_lock, own);
            chk("ready_others", bus.in_ready & ~own, '0);
            hold_chk = bus.out_valid && !bus.out_ready;
            held     = bus.out_data;
            if (hold_chk) chk("ready_stall", bus.in_ready[src], 0);
            xf = bus.in_valid[src] && bus.in_ready[src];
            if (xf) push_beat(base + W'(b), (b == n - 1), src);
            tick();
            if (hold_chk) chk("data_hold", bus.out_data, held);
            if (xf) begin
                b++;
                if (b < n) begin
                    bus.in_data[src] = base + W'(b);
                    bus.in_last[src] = (b == n - 1);
                end
            end
            cyc++;
        end
        chk("pkt_done", b, n);
        bus.in_valid[src] = 1'b0;
        bus.in_last[src]  = 1'b0;
        bus.out_ready     = 1'b1;
        #1;
        chk("lock_release", bus.arb_lock, '0);
        chk("ready_idle", bus.in_ready, '0);
        cycles = cyc;
    endtask

    initial begin
        checks = 0; errors = 0; pushed = 0; seen = 0;
        rst_n           = 1'b0;
        bus.in_valid    = '0;
        bus.in_data     = '0;
        bus.in_last     = '0;
        bus.arb_grant   = '0;
        bus.arb_granted = 1'b0;
        bus.out_ready   = 1'b1;

        repeat (3) tick();
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_last", bus.out_last, 0);
        chk("rst_out_src", bus.out_src, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_arb_lock", bus.arb_lock, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_out_valid", bus.out_valid, 0);
            chk("idle_arb_request", bus.arb_request, 0);
            chk("idle_arb_lock", bus.arb_lock, 0);
        end

        // Four beats from requester 3 at full rate.
        send_pkt(3, 4, 32'hA0, '0, 1'b0, -1, cyc_used);
        chk("pkt3_cycles", cyc_used, 4);

        // Granted with no grant bit: must stay idle.
        bus.arb_grant   = '0;
        bus.arb_granted = 1'b1;
        tick();
        bus.arb_granted = 1'b0;
        #1;
        chk("zero_grant_lock", bus.arb_lock, 0);

        send_pkt(7, 1, 32'h77, '0, 1'b0, -1, cyc_used);
        chk("pkt7_cycles", cyc_used, 1);

        // Requesters 1 and 5 compete; arbiter switches grant to 1 mid-packet.
        bus.in_valid[1] = 1'b1;
        bus.in_data[1]  = 32'hB0;
        bus.in_last[1]  = 1'b0;
        #1;
        chk("request_1_5_pre", bus.arb_request, 16'h0002);
        send_pkt(5, 3, 32'h50, 16'h0002, 1'b0, -1, cyc_used);
        chk("pkt5_cycles", cyc_used, 3);
        send_pkt(1, 2, 32'hB0, '0, 1'b0, -1, cyc_used);
        chk("pkt1_cycles", cyc_used, 2);

        send_pkt(6, 3, 32'hC0, '0, 1'b1, -1, cyc_used);
        chk("pkt6_bp_cycles", cyc_used, 5);

        // Owner stall with requester 0 waiting.
        bus.in_valid[0] = 1'b1;
        bus.in_data[0]  = 32'hD9;
        bus.in_last[0]  = 1'b1;
        send_pkt(2, 4, 32'h20, '0, 1'b0, 2, cyc_used);
        chk("pkt2_stall_cycles", cyc_used, 7);
        send_pkt(0, 1, 32'hD9, '0, 1'b0, -1, cyc_used);

        // Reset in the middle of a packet from requester 9.
        bus.in_valid[9] = 1'b1;
        bus.in_data[9]  = 32'h90;
        bus.in_last[9]  = 1'b0;
        bus.arb_grant   = 16'h0200;
        bus.arb_granted = 1'b1;
        tick();
        bus.arb_grant   = '0;
        bus.arb_granted = 1'b0;
        #1;
        chk("pkt9_ready0", bus.in_ready, 16'h0200);
        push_beat(32'h90, 1'b0, 9);
        tick();
        bus.in_data[9] = 32'h91;
        #1;
        chk("pkt9_ready1", bus.in_ready, 16'h0200);
        push_beat(32'h91, 1'b0, 9);
        tick();
        bus.in_valid[9] = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("pkt9_lock_pre_rst", bus.arb_lock, 16'h0200);
        tick();
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_arb_lock", bus.arb_lock, 0);
        chk("midrst_in_ready", bus.in_ready, 0);
        rst_n = 1'b1;
        tick();

        send_pkt(4, 1, 32'h44, '0, 1'b0, -1, cyc_used);
        repeat (3) tick();
        chk("scoreboard_empty", exp_q.size(), 0);
        chk("beats_seen", seen, pushed);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected bench completion");
        $fatal(1, "watchdog");
    end

endmodule
